// File: rtl/hci_core_mem_responder.sv
// HCI core slave endpoint: a flop-based word memory that serves loads and
// byte-enabled stores. Responses are returned in order through a small FIFO
// that honours the initiator's lrdy back-pressure.
module hci_core_mem_responder #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned BW         = 8,
    parameter int unsigned NUM_WORDS  = 256,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AW-1:0]        add_i,
    input  logic                 wen_i,
    input  logic [DW-1:0]        data_i,
    input  logic [DW/BW-1:0]     be_i,
    input  logic                 lrdy_i,
    output logic [DW-1:0]        r_data_o,
    output logic                 r_valid_o,
    output logic                 r_opc_o
);

    // Bytes per word, byte-offset bits and word-index bits.
    localparam int unsigned NB  = DW / BW;
    localparam int unsigned OFS = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IW  = $clog2(NUM_WORDS);
    // FIFO pointer and occupancy widths (count must reach RESP_DEPTH itself).
    localparam int unsigned PW  = $clog2(RESP_DEPTH);
    localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);
    // Size of the memory in bytes, one bit wider than the address so the
    // range compare can never overflow.
    localparam logic [AW:0] MEM_BYTES = (AW+1)'(NUM_WORDS * NB);

    // Memory array and its next-state image.
    logic [DW-1:0] mem_q [NUM_WORDS];
    logic [DW-1:0] mem_d [NUM_WORDS];

    // Response FIFO storage, pointers and occupancy.
    logic [DW-1:0]         fifo_data_q [RESP_DEPTH];
    logic [DW-1:0]         fifo_data_d [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] fifo_opc_q;
    logic [RESP_DEPTH-1:0] fifo_opc_d;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_ptr_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    // Request decode.
    logic [IW-1:0] word_idx;
    logic          in_range;
    logic          push;
    logic          pop;
    logic [DW-1:0] wr_mask;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] push_data;
    logic          push_opc;

    assign word_idx = add_i[OFS +: IW];
    assign in_range = ({1'b0, add_i} < MEM_BYTES);
    assign rd_word  = mem_q[word_idx];

    // Grant depends only on registered occupancy, so a full FIFO that is
    // popping this cycle still refuses the request (one bubble).
    assign gnt_o     = (count_q != CW'(RESP_DEPTH));
    assign r_valid_o = (count_q != '0);
    assign push      = req_i & gnt_o;
    assign pop       = r_valid_o & lrdy_i;

    // Expand byte enables into a bit mask, one lane per byte.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign wr_mask[gi*BW +: BW] = {BW{be_i[gi]}};
    end

    // Response payload: load data for in-range loads, zero otherwise;
    // the error flag marks any access outside the memory.
    always_comb begin
        push_data = '0;
        push_opc  = ~in_range;
        if (in_range && wen_i) begin
            push_data = rd_word;
        end
    end

    // Memory next state: merge enabled store bytes into the addressed word.
    always_comb begin
        mem_d = mem_q;
        if (push && !wen_i && in_range) begin
            mem_d[word_idx] = (mem_q[word_idx] & ~wr_mask) | (data_i & wr_mask);
        end
    end

    // Memory state; reset clears every word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // FIFO next state: push at the write pointer, pop at the read pointer;
    // pointers wrap naturally because the depth is a power of two.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_opc_d  = fifo_opc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = push_data;
            fifo_opc_d[wr_ptr_q]  = push_opc;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state; reset discards any pending responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RESP_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_opc_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fifo_data_q <= fifo_data_d;
            fifo_opc_q  <= fifo_opc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // The FIFO head drives the response; outputs are forced to zero when idle.
    always_comb begin
        r_data_o = '0;
        r_opc_o  = 1'b0;
        if (r_valid_o) begin
            r_data_o = fifo_data_q[rd_ptr_q];
            r_opc_o  = fifo_opc_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_hci_core_mem_responder.sv
// Scoreboard bench for hci_core_mem_responder: directed scenarios plus random
// traffic, checked against a byte-addressed reference memory.
module tb_hci_core_mem_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 8;
    localparam int NUM_WORDS = 256;
    localparam int RESP_DEPTH = 2;
    localparam int NB = DW / BW;
    localparam int MEM_BYTES = NUM_WORDS * NB;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i = 1'b0;
    logic          gnt_o;
    logic [AW-1:0] add_i = '0;
    logic          wen_i = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic [NB-1:0] be_i = '0;
    logic          lrdy_i = 1'b1;
    logic [DW-1:0] r_data_o;
    logic          r_valid_o;
    logic          r_opc_o;

    int errors = 0;
    int checks = 0;

    // Expected responses {opc, data}, oldest first.
    logic [DW:0] exp_q[$];
    // Reference memory, one entry per byte.
    logic [7:0]  model_mem [MEM_BYTES];
    logic [DW:0] mon_e;

    hci_core_mem_responder #(
        .DW(DW), .AW(AW), .BW(BW), .NUM_WORDS(NUM_WORDS), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .be_i(be_i),
        .lrdy_i(lrdy_i), .r_data_o(r_data_o), .r_valid_o(r_valid_o), .r_opc_o(r_opc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
    endfunction

    // Reference behaviour of one accepted transaction.
    function automatic void model_accept(input logic [AW-1:0] a, input logic w,
                                         input logic [DW-1:0] d, input logic [NB-1:0] b);
        logic [DW-1:0] rd;
        int base;
        rd = '0;
        if (a >= MEM_BYTES) begin
            exp_q.push_back({1'b1, {DW{1'b0}}});
        end else begin
            base = (int'(a) / NB) * NB;
            if (w) begin
                for (int k = 0; k < NB; k++) rd[k*BW +: BW] = model_mem[base + k];
                exp_q.push_back({1'b0, rd});
            end else begin
                for (int k = 0; k < NB; k++)
                    if (b[k]) model_mem[base + k] = d[k*BW +: BW];
                exp_q.push_back({1'b0, {DW{1'b0}}});
            end
        end
    endfunction

    // One clock cycle of stimulus: drive at posedge+1, sample grant at negedge,
    // return at the next posedge+1.
    task automatic cyc(input logic rq, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d, input logic [NB-1:0] b, input logic rdy,
                       output logic acc, output logic g);
        req_i = rq; add_i = a; wen_i = w; data_i = d; be_i = b; lrdy_i = rdy;
        @(negedge clk);
        g = gnt_o;
        acc = rq & gnt_o;
        if (acc) model_accept(a, w, d, b);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        logic acc, g;
        int n;
        n = 0;
        while ((exp_q.size() != 0 || r_valid_o) && n < budget) begin
            cyc(1'b0, '0, 1'b1, '0, '0, 1'b1, acc, g);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("drain_valid", 64'(r_valid_o), 64'd0);
    endtask

    // Monitor: compare every popped response, and idle outputs against zero.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (r_valid_o) begin
                if (lrdy_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: got data 0x%0h opc %0d, expected no response",
                                 r_data_o, r_opc_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("resp_data", 64'(r_data_o), 64'(mon_e[DW-1:0]));
                        check("resp_opc", 64'(r_opc_o), 64'(mon_e[DW]));
                    end
                end
            end else begin
                check("idle_data", 64'(r_data_o), 64'd0);
                check("idle_opc", 64'(r_opc_o), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, g;
        int grants;
        int unsigned r;
        logic [AW-1:0] a;

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 64'(gnt_o), 64'd1);
        check("rst_valid", 64'(r_valid_o), 64'd0);
        check("rst_data", 64'(r_data_o), 64'd0);
        check("rst_opc", 64'(r_opc_o), 64'd0);
        rst_ni = 1'b1;
        #1;
        check("rel_gnt", 64'(gnt_o), 64'd1);
        check("rel_valid", 64'(r_valid_o), 64'd0);

        // Load of zeroed memory, one cycle latency.
        cyc(1'b1, 32'h0, 1'b1, '0, '0, 1'b1, acc, g);
        check("t1_acc", 64'(acc), 64'd1);
        check("t1_latency", 64'(r_valid_o), 64'd1);
        check("t1_data", 64'(r_data_o), 64'd0);

        // Partial store then read-after-write.
        cyc(1'b1, 32'h10, 1'b0, 32'hAABBCCDD, 4'b0101, 1'b1, acc, g);
        check("st_valid", 64'(r_valid_o), 64'd1);
        check("st_data", 64'(r_data_o), 64'd0);
        check("st_opc", 64'(r_opc_o), 64'd0);
        cyc(1'b1, 32'h10, 1'b1, '0, '0, 1'b1, acc, g);
        check("raw_data", 64'(r_data_o), 64'h00BB00DD);

        // Preload 1..4 then back-to-back loads.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'(i * 4), 1'b0, 32'(i + 1), 4'hF, 1'b1, acc, g);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'(i * 4), 1'b1, '0, '0, 1'b1, acc, g);
            check("b2b_gnt", 64'(g), 64'd1);
            check("b2b_valid", 64'(r_valid_o), 64'd1);
            check("b2b_data", 64'(r_data_o), 64'(i + 1));
        end
        drain(10);

        // Back-pressure: only RESP_DEPTH grants, head stable.
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'(i * 4), 1'b1, '0, '0, 1'b0, acc, g);
            if (acc) grants++;
            check("bp_head_data", 64'(r_data_o), 64'd1);
        end
        check("bp_grants", 64'(grants), 64'(RESP_DEPTH));
        check("bp_gnt_low", 64'(g), 64'd0);
        cyc(1'b1, 32'h8, 1'b1, '0, '0, 1'b1, acc, g);
        check("bp_bubble", 64'(g), 64'd0);
        cyc(1'b1, 32'h8, 1'b1, '0, '0, 1'b1, acc, g);
        check("bp_regrant", 64'(g), 64'd1);
        drain(10);

        // Out-of-range accesses.
        cyc(1'b1, 32'h400, 1'b1, '0, '0, 1'b1, acc, g);
        check("oor_ld_opc", 64'(r_opc_o), 64'd1);
        check("oor_ld_data", 64'(r_data_o), 64'd0);
        cyc(1'b1, 32'h400, 1'b0, 32'hFFFFFFFF, 4'hF, 1'b1, acc, g);
        check("oor_st_opc", 64'(r_opc_o), 64'd1);
        cyc(1'b1, 32'h80000000, 1'b0, 32'hFFFFFFFF, 4'hF, 1'b1, acc, g);
        cyc(1'b1, 32'h0, 1'b1, '0, '0, 1'b1, acc, g);
        check("oor_mem_kept", 64'(r_data_o), 64'd1);
        drain(10);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) a = 32'd1024 + 32'($urandom_range(0, 4096));
            else if (r < 12) a = 32'hFFFFFFFC;
            else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            cyc(($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)), 32'($urandom),
                4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), acc, g);
        end
        drain(20);

        // Asynchronous reset with responses pending.
        cyc(1'b1, 32'h20, 1'b0, 32'h12345678, 4'hF, 1'b0, acc, g);
        cyc(1'b1, 32'h20, 1'b1, '0, '0, 1'b0, acc, g);
        req_i = 1'b0;
        check("pre_rst_valid", 64'(r_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 64'(r_valid_o), 64'd0);
        check("arst_gnt", 64'(gnt_o), 64'd1);
        check("arst_data", 64'(r_data_o), 64'd0);
        exp_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cyc(1'b1, 32'h20, 1'b1, '0, '0, 1'b1, acc, g);
        check("post_rst_valid", 64'(r_valid_o), 64'd1);
        check("post_rst_data", 64'(r_data_o), 64'd0);
        cyc(1'b1, 32'h0, 1'b1, '0, '0, 1'b1, acc, g);
        check("post_rst_data0", 64'(r_data_o), 64'd0);
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hci_core_mem_responder.md
# hci_core_mem_responder

Slave-side endpoint of the HCI core protocol: accepts `req`/`gnt` transactions from an HCI core initiator, performs loads and byte-enabled stores on an internal flop-based word memory, and returns one in-order response per transaction through a small response FIFO that honours the initiator's `lrdy` back-pressure. It serves as a TCDM/bank model in subsystem benches and as a small scratchpad behind HCI core interconnect ports; its ports map one-to-one onto the `slave` modport of `hci_core_intf` (`boffs` unused).

## Interface
- `DW`, 32, data width; multiple of `BW`.
- `AW`, 32, byte address width.
- `BW`, 8, byte width.
- `NUM_WORDS`, 256, memory depth in `DW`-bit words; power of 2.
- `RESP_DEPTH`, 2, response FIFO entries; power of 2, ≥2.

Ports:
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request grant.
- `add_i`  in  AW  byte address.
- `wen_i`  in  1  1 = load, 0 = store.
- `data_i`  in  DW  store data.
- `be_i`  in  DW/BW  byte enables.
- `lrdy_i`  in  1  initiator ready to take a response.
- `r_data_o`  out  DW  response data.
- `r_valid_o`  out  1  response valid.
- `r_opc_o`  out  1  response error flag (1 = out-of-range access).

## Operation
- Word index = `add_i[OFS +: log2(NUM_WORDS)]`, `OFS = log2(DW/BW)`; low `OFS` bits ignored.
- Out-of-range: `add_i >= NUM_WORDS*DW/BW` (compare at full `AW` width). No memory access; response `r_opc_o=1`, `r_data_o=0`.
- Handshake: transaction accepted on the rising edge where `req_i & gnt_o`. `gnt_o = (count != RESP_DEPTH)`, from registered FIFO count only — no combinational path from `lrdy_i` or `req_i` to `gnt_o`.
- Load: memory word at the index read combinationally in the accept cycle; pushed to FIFO with `r_opc=0`.
- Store: bytes with `be_i[k]=1` written at the accept edge; others unchanged. `be_i=0` is legal: accepted, no change. Response pushed with `r_data=0`, `r_opc=0`.
- Every accepted transaction yields exactly one response, in acceptance order.
- Response FIFO: head drives outputs; `r_valid_o = (count != 0)`; pop on `r_valid_o & lrdy_i`. Head payload held stable while `r_valid_o & !lrdy_i`.
- `r_data_o`, `r_opc_o` are 0 whenever `r_valid_o=0`.
- Simultaneous push and pop: count unchanged, pointers both advance (wrap modulo `RESP_DEPTH`).
- Full and popping in the same cycle: `gnt_o` stays 0 that cycle (one bubble); push allowed next cycle.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the stored bytes.

## Timing
- Reset (`rst_ni=0`, asynchronous): FIFO empty, pointers/count 0, memory all zeros. Outputs: `gnt_o=1`, `r_valid_o=0`, `r_data_o=0`, `r_opc_o=0`.
- Reset asserted mid-operation: pending responses discarded, memory cleared immediately; no response emitted after reset for pre-reset requests.
- Latency: response visible on `r_valid_o` the cycle after acceptance (1 cycle) when FIFO was empty; otherwise after all older responses are popped.
- Throughput: with `lrdy_i` held 1, one transaction per cycle sustained, `gnt_o` never drops.
- With `lrdy_i` held 0: exactly `RESP_DEPTH` transactions accepted, then `gnt_o=0` until a pop.

## Test plan
- Reset release -> `gnt_o=1`, `r_valid_o=0`; load `add=0x0` -> next cycle `r_valid_o=1`, `r_data_o=0x0`, `r_opc_o=0`.
- Store `add=0x10`, `data=0xAABBCCDD`, `be=4'b0101`; then load `0x10` -> `r_data_o=0x00BB00DD`; store response `r_data_o=0`, `r_opc_o=0`.
- Back-to-back loads 0x0,0x4,0x8,0xC (preloaded 1,2,3,4) with `lrdy_i=1` -> `gnt_o` held 1, responses 1,2,3,4 on consecutive cycles starting 1 cycle after first accept.
- `lrdy_i=0`, `req_i=1` for 4 cycles -> exactly 2 grants, then `gnt_o=0`; head data stable; raise `lrdy_i` -> both responses drain in order, `gnt_o=1` the cycle after first pop.
- Load `add=0x400` (NUM_WORDS=256) -> `r_opc_o=1`, `r_data_o=0`; store to 0x400 -> `r_opc_o=1`, memory unchanged (load 0x0 returns prior value).
- Assert `rst_ni=0` with 2 responses pending -> `r_valid_o=0` immediately (asynchronously); after release, load of previously written address returns 0.
